// File: rtl/dcp_ctl_gen.sv
// ---------------------------------------------------------------------------
// dcp_ctl_gen - DCP port bus-cycle controller.
//
// Turns a level rd/wr request from the CPU-side DCP decode into a registered
// address strobe (mas_n) or data strobe (mds_n), followed by a cycle
// acknowledge (ack_n) to the requester. Data strobes are aligned to the
// terminal count of a free-running phase divider. Strobes hold for at least
// STROBE_CYC clocks, stretch while dcp_wait is high, and are forcibly
// terminated after TIMEOUT clocks (0 disables) with a timeout_err pulse.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   sanity_n     synchronous active-low abort (same effect as reset)
//   rd_req       read request, level, held until ack
//   wr_req       write request, level, held until ack
//   la1          1 = address-register access (mas), 0 = data access (mds)
//   dcp_wait     DCP extends the current strobe while high
//   mas_n        address strobe, active low
//   mds_n        data strobe, active low
//   ack_n        cycle acknowledge, active low
//   dcp_wr       1 = current cycle is a write, latched at cycle start
//   busy         high whenever the sequencer is not idle
//   timeout_err  one-clock pulse with the first ack_n-low clock of a
//                timed-out cycle
//   phase        current divider value
// ---------------------------------------------------------------------------
module dcp_ctl_gen #(
  parameter int unsigned DIV_W      = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sanity_n,
  input  logic             rd_req,
  input  logic             wr_req,
  input  logic             la1,
  input  logic             dcp_wait,
  output logic             mas_n,
  output logic             mds_n,
  output logic             ack_n,
  output logic             dcp_wr,
  output logic             busy,
  output logic             timeout_err,
  output logic [DIV_W-1:0] phase
);

  localparam int unsigned SC_W = (STROBE_CYC < 1) ? 1 : $clog2(STROBE_CYC + 1);
  localparam int unsigned TO_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ASTB,
    S_DSTB,
    S_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SC_W-1:0]  scnt_q, scnt_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic             dcp_wr_q, dcp_wr_d;
  logic             mas_n_q, mas_n_d;
  logic             mds_n_q, mds_n_d;
  logic             ack_n_q, ack_n_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;

  logic             req;
  logic             tick;
  logic             strobe_done;
  logic             timed_out;

  always_comb begin
    req         = rd_req | wr_req;
    tick        = (div_q == '1);
    strobe_done = (scnt_q <= SC_W'(1)) && !dcp_wait;
    timed_out   = (TIMEOUT != 0) && (tcnt_q >= TO_W'(TIMEOUT));
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q + DIV_W'(1);
    scnt_d   = (scnt_q != '0) ? scnt_q - SC_W'(1) : scnt_q;
    tcnt_d   = (tcnt_q != '1) ? tcnt_q + TO_W'(1) : tcnt_q;
    dcp_wr_d = dcp_wr_q;
    terr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          // Read wins when both requests are presented together.
          dcp_wr_d = wr_req & ~rd_req;
          if (la1)       state_d = S_ASTB;
          else if (tick) state_d = S_DSTB;
          else           state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (!req)      state_d = S_IDLE;
        else if (tick) state_d = S_DSTB;
      end
      S_ASTB, S_DSTB: begin
        // A normal completion on the same edge as the timeout limit is
        // treated as a clean cycle, so no error is flagged then.
        if (strobe_done) begin
          state_d = S_ACK;
        end else if (timed_out) begin
          state_d = S_ACK;
          terr_d  = 1'b1;
        end
      end
      S_ACK: begin
        if (!req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Counters restart on strobe entry; the timeout count starts at 1 so it
    // equals the number of clocks already spent in the strobe at each edge.
    if ((state_d == S_ASTB || state_d == S_DSTB) && (state_d != state_q)) begin
      scnt_d = SC_W'(STROBE_CYC);
      tcnt_d = TO_W'(1);
    end

    if (!sanity_n) begin
      state_d  = S_IDLE;
      div_d    = '0;
      scnt_d   = '0;
      tcnt_d   = '0;
      dcp_wr_d = 1'b0;
      terr_d   = 1'b0;
    end

    // Outputs decode the next state so they move on the same edge.
    mas_n_d = (state_d != S_ASTB);
    mds_n_d = (state_d != S_DSTB);
    ack_n_d = (state_d != S_ACK);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      scnt_q   <= '0;
      tcnt_q   <= '0;
      dcp_wr_q <= 1'b0;
      mas_n_q  <= 1'b1;
      mds_n_q  <= 1'b1;
      ack_n_q  <= 1'b1;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      scnt_q   <= scnt_d;
      tcnt_q   <= tcnt_d;
      dcp_wr_q <= dcp_wr_d;
      mas_n_q  <= mas_n_d;
      mds_n_q  <= mds_n_d;
      ack_n_q  <= ack_n_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
    end
  end

  always_comb begin
    mas_n       = mas_n_q;
    mds_n       = mds_n_q;
    ack_n       = ack_n_q;
    dcp_wr      = dcp_wr_q;
    busy        = busy_q;
    timeout_err = terr_q;
    phase       = div_q;
  end

endmodule

// File: tb/tb_dcp_ctl_gen.sv
// ---------------------------------------------------------------------------
// tb_dcp_ctl_gen - directed self-checking bench for dcp_ctl_gen with default
// parameters (DIV_W=2, STROBE_CYC=2, TIMEOUT=16).
// ---------------------------------------------------------------------------
module tb_dcp_ctl_gen;

  logic       clk;
  logic       reset_n;
  logic       sanity_n;
  logic       rd_req;
  logic       wr_req;
  logic       la1;
  logic       dcp_wait;
  logic       mas_n;
  logic       mds_n;
  logic       ack_n;
  logic       dcp_wr;
  logic       busy;
  logic       timeout_err;
  logic [1:0] phase;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned low_cnt;

  dcp_ctl_gen #(
    .DIV_W      (2),
    .STROBE_CYC (2),
    .TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sanity_n    (sanity_n),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .la1         (la1),
    .dcp_wait    (dcp_wait),
    .mas_n       (mas_n),
    .mds_n       (mds_n),
    .ack_n       (ack_n),
    .dcp_wr      (dcp_wr),
    .busy        (busy),
    .timeout_err (timeout_err),
    .phase       (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the divider shows p (bounded), so the next edge samples p.
  task automatic wait_phase(input logic [1:0] p);
    for (int i = 0; i < 8 && phase !== p; i++) step();
    check("wait_phase", {30'd0, phase}, {30'd0, p});
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset_n  = 1'b0;
    sanity_n = 1'b1;
    rd_req   = 1'b0;
    wr_req   = 1'b0;
    la1      = 1'b0;
    dcp_wait = 1'b0;

    // Reset state
    #8;
    check("rst_mas_n", mas_n, 1);
    check("rst_mds_n", mds_n, 1);
    check("rst_ack_n", ack_n, 1);
    check("rst_dcp_wr", dcp_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_phase", phase, 0);
    #4;
    reset_n = 1'b1;

    // Address read, no wait: mas_n low for 2 clocks then ack
    rd_req = 1'b1;
    la1    = 1'b1;
    step();
    check("ard_mas_lo1", mas_n, 0);
    check("ard_mds_hi", mds_n, 1);
    check("ard_busy", busy, 1);
    check("ard_dcp_wr", dcp_wr, 0);
    check("ard_ack_hi", ack_n, 1);
    la1 = 1'b0; // ignored mid-cycle
    step();
    check("ard_mas_lo2", mas_n, 0);
    step();
    check("ard_mas_hi", mas_n, 1);
    check("ard_ack_lo", ack_n, 0);
    check("ard_mds_hi2", mds_n, 1);
    check("ard_terr", timeout_err, 0);
    step();
    check("ard_ack_hold", ack_n, 0);
    rd_req = 1'b0;
    step();
    check("ard_ack_rise", ack_n, 1);
    check("ard_busy_fall", busy, 0);

    // Data write aligned: request seen with phase 1 -> 2 ALIGN clocks
    wait_phase(2'd1);
    wr_req = 1'b1;
    la1    = 1'b0;
    step();
    check("dwr_align_mds", mds_n, 1);
    check("dwr_align_busy", busy, 1);
    check("dwr_dcp_wr", dcp_wr, 1);
    check("dwr_phase2", phase, 2);
    step();
    check("dwr_align2_mds", mds_n, 1);
    check("dwr_phase3", phase, 3);
    step();
    check("dwr_mds_lo1", mds_n, 0);
    check("dwr_phase0", phase, 0);
    step();
    check("dwr_mds_lo2", mds_n, 0);
    step();
    check("dwr_mds_hi", mds_n, 1);
    check("dwr_ack_lo", ack_n, 0);
    wr_req = 1'b0;
    step();
    check("dwr_idle", busy, 0);

    // Data read with wait high for 5 clocks -> mds_n low 6 clocks
    wait_phase(2'd3);
    rd_req   = 1'b1;
    la1      = 1'b0;
    dcp_wait = 1'b1;
    step();
    check("wt_mds_start", mds_n, 0);
    check("wt_dcp_wr", dcp_wr, 0);
    low_cnt = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mds_n === 1'b0) low_cnt++;
    end
    dcp_wait = 1'b0;
    step();
    check("wt_low_clocks", low_cnt, 6);
    check("wt_mds_hi", mds_n, 1);
    check("wt_ack_lo", ack_n, 0);
    check("wt_terr", timeout_err, 0);
    rd_req = 1'b0;
    step();
    check("wt_idle", busy, 0);

    // Timeout: wait stuck high -> 16 strobe clocks then ack with terr pulse
    wait_phase(2'd3);
    rd_req   = 1'b1;
    dcp_wait = 1'b1;
    step();
    low_cnt = 1;
    for (int i = 0; i < 40 && mds_n === 1'b0; i++) begin
      step();
      if (mds_n === 1'b0) low_cnt++;
    end
    check("to_low_clocks", low_cnt, 16);
    check("to_mds_hi", mds_n, 1);
    check("to_ack_lo", ack_n, 0);
    check("to_terr_pulse", timeout_err, 1);
    step();
    check("to_terr_fall", timeout_err, 0);
    check("to_ack_hold", ack_n, 0);
    rd_req   = 1'b0;
    dcp_wait = 1'b0;
    step();
    check("to_idle", busy, 0);
    check("to_ack_rise", ack_n, 1);

    // Request dropped during ALIGN -> idle, no strobe
    wait_phase(2'd0);
    wr_req = 1'b1;
    step();
    check("dal_busy", busy, 1);
    check("dal_mds_hi", mds_n, 1);
    wr_req = 1'b0;
    step();
    check("dal_idle", busy, 0);
    check("dal_mds_hi2", mds_n, 1);
    check("dal_ack_hi", ack_n, 1);

    // sanity_n abort mid-DSTB, then a normal address read
    wait_phase(2'd3);
    rd_req = 1'b1;
    step();
    check("san_mds_lo", mds_n, 0);
    sanity_n = 1'b0;
    step();
    check("san_mds_hi", mds_n, 1);
    check("san_ack_hi", ack_n, 1);
    check("san_busy", busy, 0);
    check("san_phase", phase, 0);
    sanity_n = 1'b1;
    la1      = 1'b1;
    step();
    check("san_next_mas_lo", mas_n, 0);
    check("san_next_phase", phase, 1);
    step();
    step();
    check("san_next_ack_lo", ack_n, 0);
    check("san_next_mas_hi", mas_n, 1);
    rd_req = 1'b0;
    step();
    check("san_next_idle", busy, 0);

    // Both requests high, la1=1 -> read; async reset mid-ASTB
    step();
    rd_req = 1'b1;
    wr_req = 1'b1;
    la1    = 1'b1;
    step();
    check("both_mas_lo", mas_n, 0);
    check("both_dcp_wr", dcp_wr, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_mas_hi", mas_n, 1);
    check("arst_busy", busy, 0);
    check("arst_ack_hi", ack_n, 1);
    rd_req = 1'b0;
    wr_req = 1'b0;
    #1;
    reset_n = 1'b1;
    step();
    check("arst_no_ack", ack_n, 1);
    check("arst_phase", phase, 1);
    check("arst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
